// File: rtl/sr_bank_pkg.sv
// Shared mode codes and next-state function for the sr_flop_bank channels.
package sr_bank_pkg;

   localparam logic [1:0] MODE_HOLD    = 2'd0;
   localparam logic [1:0] MODE_SET_DOM = 2'd1;
   localparam logic [1:0] MODE_RST_DOM = 2'd2;
   localparam logic [1:0] MODE_TOGGLE  = 2'd3;

   // Clocked SR rule; the S=R=1 case is resolved by mode.
   function automatic logic sr_next(input logic s, input logic r, input logic q,
                                    input logic [1:0] mode);
      logic nq;
      nq = q;
      unique case ({s, r})
         2'b00: nq = q;
         2'b01: nq = 1'b0;
         2'b10: nq = 1'b1;
         default: begin
            unique case (mode)
               MODE_HOLD:    nq = q;
               MODE_SET_DOM: nq = 1'b1;
               MODE_RST_DOM: nq = 1'b0;
               MODE_TOGGLE:  nq = ~q;
               default:      nq = q;
            endcase
         end
      endcase
      return nq;
   endfunction

endpackage

// File: rtl/sr_cell.sv
// One clocked SR channel: state, complement, edge pulses, invalid flag and
// (with SR_INVALID_CNT_EN) a saturating invalid-occurrence counter.
module sr_cell
   import sr_bank_pkg::*;
#(
   parameter int unsigned MODE    = 0,
   parameter logic        RST_VAL = 1'b0
`ifdef SR_INVALID_CNT_EN
   ,
   parameter int unsigned CW      = 8
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          s,
   input  logic          r,
`ifdef SR_INVALID_CNT_EN
   input  logic          inv_clr,
   output logic [CW-1:0] inv_cnt,
`endif
   output logic          q,
   output logic          q_n,
   output logic          q_rise,
   output logic          q_fall,
   output logic          invalid
);

   logic q_nxt;
   logic both_c;

   // Disabled cycles keep q_nxt == q, which also suppresses the pulses.
   always_comb begin
      q_nxt  = q;
      both_c = en & s & r;
      if (en) q_nxt = sr_next(s, r, q, 2'(MODE));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q       <= RST_VAL;
         q_n     <= ~RST_VAL;
         q_rise  <= 1'b0;
         q_fall  <= 1'b0;
         invalid <= 1'b0;
      end else begin
         q       <= q_nxt;
         q_n     <= ~q_nxt;
         q_rise  <= ~q & q_nxt;
         q_fall  <= q & ~q_nxt;
         invalid <= both_c;
      end
   end

`ifdef SR_INVALID_CNT_EN
   localparam logic [CW-1:0] CNT_MAX = '1;

   // Clear beats a simultaneous increment; the count sticks at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inv_cnt <= '0;
      end else if (inv_clr) begin
         inv_cnt <= '0;
      end else if (both_c && (inv_cnt != CNT_MAX)) begin
         inv_cnt <= inv_cnt + CW'(1);
      end
   end
`endif

endmodule

// File: rtl/sr_flop_bank.sv
// Bank of N independent clocked SR cells. Define SR_INVALID_CNT_EN to add
// per-channel saturating invalid counters and the inv_clr/inv_cnt ports.
module sr_flop_bank
   import sr_bank_pkg::*;
#(
   parameter int unsigned    N       = 4,
   parameter int unsigned    MODE    = 0,
   parameter logic [N-1:0]   RST_VAL = '0,
   parameter int unsigned    CW      = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [N-1:0]    s,
   input  logic [N-1:0]    r,
`ifdef SR_INVALID_CNT_EN
   input  logic            inv_clr,
   output logic [N*CW-1:0] inv_cnt,
`endif
   output logic [N-1:0]    q,
   output logic [N-1:0]    q_n,
   output logic [N-1:0]    q_rise,
   output logic [N-1:0]    q_fall,
   output logic [N-1:0]    invalid
);

   if (MODE > 3 || N < 1 || N > 32 || CW < 1) begin : g_bad_param
      $error("sr_flop_bank: illegal parameters N=%0d MODE=%0d CW=%0d", N, MODE, CW);
   end

   for (genvar i = 0; i < N; i++) begin : g_cell
      sr_cell #(
         .MODE    (MODE),
         .RST_VAL (RST_VAL[i])
`ifdef SR_INVALID_CNT_EN
         ,
         .CW      (CW)
`endif
      ) u_cell (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (en),
         .s       (s[i]),
         .r       (r[i]),
`ifdef SR_INVALID_CNT_EN
         .inv_clr (inv_clr),
         .inv_cnt (inv_cnt[i*CW +: CW]),
`endif
         .q       (q[i]),
         .q_n     (q_n[i]),
         .q_rise  (q_rise[i]),
         .q_fall  (q_fall[i]),
         .invalid (invalid[i])
      );
   end

endmodule

// File: tb/tb_sr_flop_bank.sv
// Scoreboard bench for sr_flop_bank: four instances, one per MODE, share stimulus.
module tb_sr_flop_bank;

   localparam int unsigned N  = 4;
   localparam int unsigned CW = 2;
   localparam logic [3:0]  RV = 4'b1010;

   typedef struct packed {
      logic [3:0] q, qn, rise, fall, inv;
      logic [7:0] cnt;
   } obs_t;
   typedef obs_t [3:0] obs4_t;

   logic       clk = 1'b0;
   logic       rst_n, en, clr;
   logic [3:0] s, r;
   logic [3:0] q_o [4];
   logic [3:0] qn_o [4];
   logic [3:0] rise_o [4];
   logic [3:0] fall_o [4];
   logic [3:0] inv_o [4];
   logic [7:0] cnt_o [4];

   logic [3:0] mq [4];
   logic [1:0] mc [4][4];
   obs4_t      exp_q [$];
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      sr_flop_bank #(.N(N), .MODE(g), .RST_VAL(RV), .CW(CW)) u_dut (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (en),
         .s       (s),
         .r       (r),
`ifdef SR_INVALID_CNT_EN
         .inv_clr (clr),
         .inv_cnt (cnt_o[g]),
`endif
         .q       (q_o[g]),
         .q_n     (qn_o[g]),
         .q_rise  (rise_o[g]),
         .q_fall  (fall_o[g]),
         .invalid (inv_o[g])
      );
`ifndef SR_INVALID_CNT_EN
      assign cnt_o[g] = 8'h00;
`endif
   end

   function automatic obs4_t observe();
      obs4_t o;
      for (int m = 0; m < 4; m++) begin
         o[m].q    = q_o[m];
         o[m].qn   = qn_o[m];
         o[m].rise = rise_o[m];
         o[m].fall = fall_o[m];
         o[m].inv  = inv_o[m];
         o[m].cnt  = cnt_o[m];
      end
      return o;
   endfunction

   // Update the reference model, push its prediction, then apply one clock.
   task automatic drive(input logic rn, input logic e, input logic [3:0] ss,
                        input logic [3:0] rr, input logic cl);
      obs4_t ex;
      logic  oq, nq, bad;
      for (int m = 0; m < 4; m++) begin
         for (int c = 0; c < 4; c++) begin
            oq = mq[m][c];
            nq = oq;
            bad = e & ss[c] & rr[c];
            if (!rn) begin
               nq = RV[c];
               mc[m][c] = 2'd0;
            end else begin
               if (e && ss[c] && !rr[c]) nq = 1'b1;
               else if (e && !ss[c] && rr[c]) nq = 1'b0;
               else if (bad) begin
                  if (m == 1) nq = 1'b1;
                  else if (m == 2) nq = 1'b0;
                  else if (m == 3) nq = ~oq;
               end
`ifdef SR_INVALID_CNT_EN
               if (cl) mc[m][c] = 2'd0;
               else if (bad && mc[m][c] != 2'd3) mc[m][c] = mc[m][c] + 2'd1;
`endif
            end
            ex[m].q[c]    = nq;
            ex[m].qn[c]   = ~nq;
            ex[m].rise[c] = rn & ~oq & nq;
            ex[m].fall[c] = rn & oq & ~nq;
            ex[m].inv[c]  = rn & bad;
            ex[m].cnt[c*2 +: 2] = mc[m][c];
            mq[m][c] = nq;
         end
      end
      exp_q.push_back(ex);
      rst_n = rn; en = e; s = ss; r = rr; clr = cl;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      obs4_t got, ex;
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0);
         got = observe(); ex = exp_q.pop_front(); checks++;
         if (got !== ex) begin
            failures++;
            $display("FAIL reset_sb got=%h exp=%h", got, ex);
         end
      end
      for (int m = 0; m < 4; m++) begin
         checks++;
         if (q_o[m] !== 4'b1010 || qn_o[m] !== 4'b0101 || rise_o[m] !== 4'h0 ||
             fall_o[m] !== 4'h0 || inv_o[m] !== 4'h0 || cnt_o[m] !== 8'h00) begin
            failures++;
            $display("FAIL reset_val mode=%0d q=%b qn=%b rise=%b fall=%b inv=%b cnt=%h exp q=1010 qn=0101 rest=0",
                     m, q_o[m], qn_o[m], rise_o[m], fall_o[m], inv_o[m], cnt_o[m]);
         end
      end
   endtask

   task automatic test_set_reset();
      obs4_t got, ex;
      drive(1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0);
      got = observe(); ex = exp_q.pop_front(); checks++;
      if (got !== ex || q_o[0] !== 4'b1011 || rise_o[0] !== 4'b0001) begin
         failures++;
         $display("FAIL set_ch0 got=%h exp=%h q0=%b rise0=%b exp q0=1011 rise0=0001", got, ex, q_o[0], rise_o[0]);
      end
      drive(1'b1, 1'b1, 4'b0000, 4'b0001, 1'b0);
      got = observe(); ex = exp_q.pop_front(); checks++;
      if (got !== ex || q_o[0] !== 4'b1010 || fall_o[0] !== 4'b0001 || rise_o[0] !== 4'b0000) begin
         failures++;
         $display("FAIL reset_ch0 got=%h exp=%h q0=%b fall0=%b exp q0=1010 fall0=0001", got, ex, q_o[0], fall_o[0]);
      end
   endtask

   task automatic test_mode_sweep();
      obs4_t      got, ex;
      logic [2:0] want [4];
      want[0] = 3'b000; want[1] = 3'b111; want[2] = 3'b000; want[3] = 3'b101;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b1, 4'b0001, 4'b0001, 1'b0);
         got = observe(); ex = exp_q.pop_front(); checks++;
         if (got !== ex) begin
            failures++;
            $display("FAIL mode_sb cycle=%0d got=%h exp=%h", k, got, ex);
         end
         for (int m = 0; m < 4; m++) begin
            checks++;
            if (q_o[m][0] !== want[m][2-k] || inv_o[m][0] !== 1'b1) begin
               failures++;
               $display("FAIL mode_q mode=%0d cycle=%0d q0=%b inv0=%b exp q0=%b inv0=1",
                        m, k, q_o[m][0], inv_o[m][0], want[m][2-k]);
            end
         end
      end
   endtask

   task automatic test_enable();
      obs4_t got, ex;
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 1'b0, 4'b1111, (k == 2) ? 4'b1111 : 4'b0000, 1'b0);
         got = observe(); ex = exp_q.pop_front(); checks++;
         if (got !== ex || (rise_o[3] | fall_o[3] | inv_o[3]) !== 4'h0) begin
            failures++;
            $display("FAIL enable_gate cycle=%0d got=%h exp=%h", k, got, ex);
         end
      end
   endtask

   task automatic test_counter();
      obs4_t got, ex;
      drive(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
      void'(exp_q.pop_front());
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0);
         got = observe(); ex = exp_q.pop_front(); checks++;
         if (got !== ex) begin
            failures++;
            $display("FAIL cnt_inc cycle=%0d got=%h exp=%h", k, got, ex);
         end
      end
`ifdef SR_INVALID_CNT_EN
      checks++;
      if (cnt_o[1] !== 8'hFF) begin
         failures++;
         $display("FAIL cnt_sat got=%h exp=ff", cnt_o[1]);
      end
`endif
      drive(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1);
      got = observe(); ex = exp_q.pop_front(); checks++;
      if (got !== ex || cnt_o[2] !== 8'h00 || inv_o[2] !== 4'hF) begin
         failures++;
         $display("FAIL cnt_clr got=%h exp=%h cnt=%h inv=%b", got, ex, cnt_o[2], inv_o[2]);
      end
      drive(1'b1, 1'b1, 4'b0101, 4'b0111, 1'b0);
      got = observe(); ex = exp_q.pop_front(); checks++;
      if (got !== ex) begin
         failures++;
         $display("FAIL cnt_after_clr got=%h exp=%h", got, ex);
      end
   endtask

   task automatic test_mid_reset();
      obs4_t got, ex;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0);
         void'(exp_q.pop_front());
      end
      drive(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0);
      got = observe(); ex = exp_q.pop_front(); checks++;
      if (got !== ex || q_o[3] !== RV || (rise_o[3] | fall_o[3] | inv_o[3]) !== 4'h0) begin
         failures++;
         $display("FAIL mid_reset got=%h exp=%h q3=%b rise3=%b fall3=%b", got, ex, q_o[3], rise_o[3], fall_o[3]);
      end
      drive(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
      got = observe(); ex = exp_q.pop_front(); checks++;
      if (got !== ex || (rise_o[3] | fall_o[3]) !== 4'h0) begin
         failures++;
         $display("FAIL post_reset_hold got=%h exp=%h", got, ex);
      end
   endtask

   task automatic test_back_to_back();
      obs4_t got, ex;
      for (int k = 0; k < 60; k++) begin
         drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
               4'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0));
         got = observe(); ex = exp_q.pop_front(); checks++;
         if (got !== ex) begin
            failures++;
            $display("FAIL random cycle=%0d got=%h exp=%h", k, got, ex);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; clr = 1'b0; s = 4'h0; r = 4'h0;
      @(posedge clk);
      #1;
      test_reset();
      test_set_reset();
      test_mode_sweep();
      test_enable();
      test_counter();
      test_mid_reset();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain left=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
